// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: issues instruction fetches at pc_q, holds the fetched
// word for decode, and steers the external PC register on sequential flow and redirects.
module pc_fetch_ctrl #(
  parameter int            N          = 32,
  parameter logic [N-1:0]  EXC_VECTOR = N'(32'h80000180)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  pc_q,
  output logic [N-1:0]  pc_d,
  output logic          pc_ena,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr,
  output logic [N-1:0]  instr_pc,
  output logic          instr_valid,
  input  logic          instr_accept,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_target,
  output logic          misalign_exc
);

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    FETCH      = 2'd1,
    HOLD       = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  pending;
  logic [N-1:0]  resolved;
  logic          redirect_live;
  logic          load_instr;
  logic          load_pend;

  // Word-aligned targets pass through; anything else traps to the exception vector.
  function automatic logic [N-1:0] resolve_target(input logic [N-1:0] target);
    if (target[1:0] == 2'b00) begin
      return target;
    end
    return EXC_VECTOR;
  endfunction

  assign resolved      = resolve_target(redirect_target);
  assign redirect_live = redirect && (state != RESET_WAIT);

  // imem_addr tracks pc_q; pc_q is only written on the cycle a request completes,
  // so the address is stable for the lifetime of every outstanding request.
  assign imem_addr   = pc_q;
  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign instr_valid = (state == HOLD);

  always_comb begin
    state_next = state;
    pc_d       = pc_q + N'(4);
    pc_ena     = 1'b0;
    load_instr = 1'b0;
    load_pend  = 1'b0;
    unique case (state)
      RESET_WAIT: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          pc_ena = 1'b1;
          if (redirect) begin
            pc_d = resolved;
          end else begin
            load_instr = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect) begin
          load_pend  = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // A same-cycle redirect is younger than the pending one and takes priority.
        if (imem_ready) begin
          pc_ena     = 1'b1;
          pc_d       = redirect ? resolved : pending;
          state_next = FETCH;
        end else if (redirect) begin
          load_pend = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_ena     = 1'b1;
          pc_d       = resolved;
          state_next = FETCH;
        end else if (instr_accept) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = RESET_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_WAIT;
      instr        <= '0;
      instr_pc     <= '0;
      pending      <= '0;
      misalign_exc <= 1'b0;
    end else begin
      state        <= state_next;
      misalign_exc <= redirect_live && (redirect_target[1:0] != 2'b00);
      if (load_instr) begin
        instr    <= imem_rdata;
        instr_pc <= pc_q;
      end
      if (load_pend) begin
        pending <= resolved;
      end
    end
  end

endmodule
